serial_comparator_32: RTL and testbench
=======================================

# serial_comparator_32

Multicycle signed 32-bit magnitude comparator for the ALU compare path. It walks the operands two bits per cycle, MSB-first, through the same EQ/GT cascade rule used by the 2-bit comparator slices. It exits early as soon as the operands are known to differ. It produces the `isNotEqual` and `isLessThan` flags consumed by the branch logic (`bne`/`blt`) and a one-cycle result-ready strobe.

## Interface
Parameters: none (width fixed at 32, slice width fixed at 2).

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge
- `reset`  in  1  asynchronous, active-high; forces IDLE and clears all outputs
- `ctrl_start`  in  1  request a compare; sampled on the rising edge
- `data_operandA`  in  32  operand A, two's complement; captured on the accepted start edge
- `data_operandB`  in  32  operand B, two's complement; captured on the accepted start edge
- `busy`  out  1  high while state is BUSY
- `data_resultRDY`  out  1  high for exactly one cycle (state DONE)
- `isNotEqual`  out  1  registered; 1 iff A != B for the last completed compare
- `isLessThan`  out  1  registered; 1 iff A < B (signed) for the last completed compare

## Operation
- **State machine: IDLE, BUSY, DONE.**
  - IDLE: if `ctrl_start`, go to BUSY; otherwise stay in IDLE.
  - BUSY: process one slice per edge.
  - DONE: if `ctrl_start`, go to BUSY; otherwise go to IDLE.
  - `ctrl_start` in BUSY is ignored; operands are not re-captured.
- **Accept edge:**
  - Latch the operands with bit 31 of both A and B inverted. This is the sign flip, so the unsigned cascade yields the signed order.
  - Set `eq=1`, `gt=0`, slice counter `cnt=15`.
- **BUSY edge:** process slice `a=A[2cnt+1:2cnt]`, `b=B[2cnt+1:2cnt]`.
  - `eq_n = (a==b) & eq & ~gt`
  - `gt_n = ((a>b) & eq & ~gt) | (~eq & gt)`
  - Update `eq<=eq_n`, `gt<=gt_n`.
  - If `eq_n==0` or `cnt==0`: go to DONE, with `isNotEqual<=~eq_n` and `isLessThan<=~eq_n & ~gt_n`.
  - Otherwise `cnt<=cnt-1`.
- `isNotEqual` and `isLessThan` hold their values until the next entry into DONE. They do not change during BUSY.
- `cnt` is 4 bits, decrements without wrap, and is never decremented below 0.
- **Reset (any time, including mid-BUSY):**
  - Immediately: state IDLE, `busy=0`, `data_resultRDY=0`, `isNotEqual=0`, `isLessThan=0`, `eq=1`, `gt=0`, `cnt=0`.
  - An in-flight compare is discarded with no RDY pulse.
  - If `ctrl_start` is high on the first edge after reset deasserts, it is accepted.

## Timing
- Let `t0` be the accepting edge.
- **Latency:** let k be the index of the first slice, counting from 15 down, where the operands differ. If they are equal, k=0. With n = 16-k slices processed:
  - DONE is entered on edge `t0+n`.
  - `data_resultRDY` is high from `t0+n` to `t0+n+1`.
  - Minimum n is 1 (sign/top slice differs); maximum n is 16 (equal operands, or a difference only in slice 0).
- `busy` is high from `t0` to `t0+n`.
- **Back-to-back:** a start sampled during DONE (edge `t0+n+1`) is accepted with no IDLE cycle. That next compare's RDY arrives no earlier than 1 edge later.
- Operand inputs are don't-care except on the accept edge.

## Test plan
- A=5, B=5, start at `t0` -> `busy` high for 16 cycles; RDY at `t0+16` for one cycle; `isNotEqual=0`, `isLessThan=0`.
- A=0xFFFFFFFF (−1), B=0x00000001, start -> RDY at `t0+1`; `isNotEqual=1`, `isLessThan=1`.
- A=0x80000000, B=0x7FFFFFFF -> RDY at `t0+1`, `isLessThan=1`. Swapped operands -> RDY at `t0+1`, `isNotEqual=1`, `isLessThan=0`.
- A=0x00000002, B=0x00000003 -> RDY at `t0+16`, `isNotEqual=1`, `isLessThan=1`. Then A=0x00000300, B=0x00000200 started in DONE -> RDY at `t0'+12`, `isLessThan=0`, `isNotEqual=1`.
- Start A=B=0, then assert `ctrl_start` with A=1, B=0 at `t0+5` (while BUSY) -> ignored; RDY at `t0+16` with `isNotEqual=0`; `busy` never re-asserts early.
- Start A=0x12345678, B=0x12345679; assert `reset` at `t0+7` -> outputs and `busy` go to 0 immediately; no RDY pulse follows. A new start after reset deasserts completes normally in 16 cycles.

Source files
------------

// File: rtl/serial_comparator_32.sv
// Multicycle signed 32-bit comparator. Walks the operands two bits per cycle,
// MSB first, and stops at the first differing slice.
module serial_comparator_32 (
  input  logic        clock,
  input  logic        reset,
  input  logic        ctrl_start,
  input  logic [31:0] data_operandA,
  input  logic [31:0] data_operandB,
  output logic        busy,
  output logic        data_resultRDY,
  output logic        isNotEqual,
  output logic        isLessThan
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic        eq_q, eq_d, gt_q, gt_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        ne_q, ne_d, lt_q, lt_d;

  logic [1:0]  slice_a, slice_b;
  logic        eq_n, gt_n, last, accept;

  assign accept  = ctrl_start & (state_q != StBusy);
  assign slice_a = a_q[{cnt_q, 1'b0} +: 2];
  assign slice_b = b_q[{cnt_q, 1'b0} +: 2];
  assign eq_n    = (slice_a == slice_b) & eq_q & ~gt_q;
  assign gt_n    = ((slice_a > slice_b) & eq_q & ~gt_q) | (~eq_q & gt_q);
  assign last    = ~eq_n | (cnt_q == 4'd0);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  state_d = ctrl_start ? StBusy : StIdle;
      StBusy:  state_d = last ? StDone : StBusy;
      StDone:  state_d = ctrl_start ? StBusy : StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    busy           = (state_q == StBusy);
    data_resultRDY = (state_q == StDone);
    isNotEqual     = ne_q;
    isLessThan     = lt_q;
  end

  // Datapath next state
  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    eq_d  = eq_q;
    gt_d  = gt_q;
    cnt_d = cnt_q;
    ne_d  = ne_q;
    lt_d  = lt_q;
    if (accept) begin
      // Flipping both sign bits lets the unsigned cascade produce signed order.
      a_d   = {~data_operandA[31], data_operandA[30:0]};
      b_d   = {~data_operandB[31], data_operandB[30:0]};
      eq_d  = 1'b1;
      gt_d  = 1'b0;
      cnt_d = 4'd15;
    end else if (state_q == StBusy) begin
      eq_d = eq_n;
      gt_d = gt_n;
      if (last) begin
        ne_d = ~eq_n;
        lt_d = ~eq_n & ~gt_n;
      end else begin
        cnt_d = cnt_q - 4'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_q   <= 32'd0;
      b_q   <= 32'd0;
      eq_q  <= 1'b1;
      gt_q  <= 1'b0;
      cnt_q <= 4'd0;
      ne_q  <= 1'b0;
      lt_q  <= 1'b0;
    end else begin
      a_q   <= a_d;
      b_q   <= b_d;
      eq_q  <= eq_d;
      gt_q  <= gt_d;
      cnt_q <= cnt_d;
      ne_q  <= ne_d;
      lt_q  <= lt_d;
    end
  end

endmodule

// File: tb/tb_serial_comparator_32.sv
// Self-checking bench for serial_comparator_32: expected flags and latency are
// queued at start and checked when the result-ready strobe appears.
module tb_serial_comparator_32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ctrl_start = 1'b0;
  logic [31:0] data_operandA = 32'd0;
  logic [31:0] data_operandB = 32'd0;
  logic        busy, data_resultRDY, isNotEqual, isLessThan;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic ne;
    logic lt;
    int   n;
  } exp_t;

  exp_t sb_q[$];

  serial_comparator_32 dut (
    .clock         (clock),
    .reset         (reset),
    .ctrl_start    (ctrl_start),
    .data_operandA (data_operandA),
    .data_operandB (data_operandB),
    .busy          (busy),
    .data_resultRDY(data_resultRDY),
    .isNotEqual    (isNotEqual),
    .isLessThan    (isLessThan)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    bit   found;
    e.ne  = (a != b);
    e.lt  = ($signed(a) < $signed(b));
    e.n   = 16;
    found = 0;
    for (int k = 15; k >= 0; k--) begin
      if (!found && (a[2*k +: 2] != b[2*k +: 2])) begin
        e.n   = 16 - k;
        found = 1;
      end
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts a compare from IDLE or DONE and checks the result against the scoreboard.
  // poke_at > 0 raises ctrl_start with different operands on that BUSY edge.
  task automatic run_cmp(input logic [31:0] a, input logic [31:0] b, input int poke_at,
                         input bit check_idle);
    exp_t e;
    int   cyc;
    bit   busy_ok, hold_ok;
    logic ne0, lt0;
    sb_q.push_back(model(a, b));
    data_operandA = a;
    data_operandB = b;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start    = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
    cyc     = 0;
    busy_ok = 1;
    hold_ok = 1;
    ne0     = isNotEqual;
    lt0     = isLessThan;
    while (!data_resultRDY && cyc < 40) begin
      if (!busy) busy_ok = 0;
      if (isNotEqual !== ne0 || isLessThan !== lt0) hold_ok = 0;
      if (poke_at > 0 && cyc == poke_at - 1) begin
        ctrl_start    = 1'b1;
        data_operandA = 32'd1;
        data_operandB = 32'd0;
      end else begin
        ctrl_start = 1'b0;
      end
      tick();
      cyc++;
    end
    ctrl_start = 1'b0;
    e = sb_q.pop_front();
    n_vec++;
    if (!data_resultRDY) begin
      n_err++;
      $display("FAIL rdy_timeout a=%h b=%h: no RDY after %0d cycles, required at %0d",
               a, b, cyc, e.n);
      return;
    end
    n_vec++;
    if (cyc !== e.n) begin
      n_err++;
      $display("FAIL latency a=%h b=%h: got %0d required %0d", a, b, cyc, e.n);
    end
    n_vec++;
    if (isNotEqual !== e.ne) begin
      n_err++;
      $display("FAIL isNotEqual a=%h b=%h: got %b required %b", a, b, isNotEqual, e.ne);
    end
    n_vec++;
    if (isLessThan !== e.lt) begin
      n_err++;
      $display("FAIL isLessThan a=%h b=%h: got %b required %b", a, b, isLessThan, e.lt);
    end
    n_vec++;
    if (busy !== 1'b0 || busy_ok !== 1'b1) begin
      n_err++;
      $display("FAIL busy_window a=%h b=%h: busy_at_rdy=%b busy_held=%b required 0/1",
               a, b, busy, busy_ok);
    end
    n_vec++;
    if (hold_ok !== 1'b1) begin
      n_err++;
      $display("FAIL flag_hold a=%h b=%h: flags changed during BUSY, required stable", a, b);
    end
    if (check_idle) begin
      tick();
      n_vec++;
      if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
        n_err++;
        $display("FAIL rdy_one_cycle a=%h b=%h: rdy=%b busy=%b required 0/0",
                 a, b, data_resultRDY, busy);
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    n_vec++;
    if ({busy, data_resultRDY, isNotEqual, isLessThan} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_state: busy/rdy/ne/lt=%b required 0000",
               {busy, data_resultRDY, isNotEqual, isLessThan});
    end
    reset = 1'b0;
    tick();
    n_vec++;
    if ({busy, data_resultRDY} !== 2'b00) begin
      n_err++;
      $display("FAIL idle_after_reset: busy/rdy=%b required 00", {busy, data_resultRDY});
    end
  endtask

  task automatic test_directed();
    logic [31:0] ta[6];
    logic [31:0] tb[6];
    ta = '{32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'd2};
    tb = '{32'd5, 32'h0000_0001, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0000_0000, 32'd3};
    for (int i = 0; i < 6; i++) run_cmp(ta[i], tb[i], 0, 1);
  endtask

  task automatic test_reset_midflight();
    int cyc;
    bit rdy_seen;
    sb_q.push_back(model(32'h1234_5678, 32'h1234_5679));
    data_operandA = 32'h1234_5678;
    data_operandB = 32'h1234_5679;
    ctrl_start    = 1'b1;
    tick();
    ctrl_start = 1'b0;
    rdy_seen   = 0;
    for (cyc = 0; cyc < 7; cyc++) begin
      tick();
      if (data_resultRDY) rdy_seen = 1;
    end
    n_vec++;
    if (busy !== 1'b1 || rdy_seen || isNotEqual !== 1'b1 || isLessThan !== 1'b1) begin
      n_err++;
      $display("FAIL midflight_pre: busy=%b rdy_seen=%b ne=%b lt=%b required 1 0 1 1",
               busy, rdy_seen, isNotEqual, isLessThan);
    end
    reset = 1'b1;
    #1;
    n_vec++;
    if ({busy, data_resultRDY, isNotEqual, isLessThan} !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: busy/rdy/ne/lt=%b required 0000",
               {busy, data_resultRDY, isNotEqual, isLessThan});
    end
    void'(sb_q.pop_front());
    rdy_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (data_resultRDY || busy) rdy_seen = 1;
    end
    reset = 1'b0;
    n_vec++;
    if (rdy_seen) begin
      n_err++;
      $display("FAIL discarded_compare: rdy or busy seen during reset, required none");
    end
    // Start is raised in the same window reset drops, so the first edge accepts it.
    run_cmp(32'h1234_5678, 32'h1234_5679, 0, 1);
  endtask

  task automatic test_back_to_back();
    run_cmp(32'd2, 32'd3, 0, 0);
    run_cmp(32'h0000_0300, 32'h0000_0200, 0, 1);
  endtask

  task automatic test_start_ignored();
    run_cmp(32'd0, 32'd0, 5, 1);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    for (int i = 0; i < 16; i++) begin
      a = $urandom;
      case (i % 4)
        0:       b = $urandom;
        1:       b = a ^ (32'd1 << $urandom_range(31, 0));
        2:       b = a;
        default: b = a ^ (32'd3 << (2 * $urandom_range(15, 0)));
      endcase
      run_cmp(a, b, 0, 1);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_reset_midflight();
    test_back_to_back();
    test_start_ignored();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
